// File: rtl/nec_decode_gather_pkg.sv
// rtl/nec_decode_gather_pkg.sv - shared types and constants for the NEC decode byte gatherer
//   gather_state_e : gatherer FSM states
//   gather_entry_t : one completed instruction as held in the output queue
//   desc_total     : 4-bit instruction length from a predecoder descriptor

package nec_decode_gather_pkg;

    // Byte capacity of a queue entry; the top-level MAX_LEN must not exceed it.
    localparam int ENTRY_MAX_LEN = 8;
    localparam int MAX_DISP      = 2;
    localparam int MAX_IMM       = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        GATHER = 1'b1
    } gather_state_e;

    typedef struct packed {
        logic [8*ENTRY_MAX_LEN-1:0] bytes;
        logic [3:0]                 len;
        logic [15:0]                pc;
        logic [15:0]                end_pc;
        logic                       bad;
    } gather_entry_t;

    // Deliberately truncated to 4 bits: oversized descriptors that wrap are
    // judged on the wrapped value.
    function automatic logic [3:0] desc_total(input logic [2:0] hdr,
                                              input logic [2:0] disp,
                                              input logic [2:0] imm);
        return 4'(hdr) + 4'(disp) + 4'(imm);
    endfunction

endpackage

// File: rtl/nec_decode_queue.sv
// rtl/nec_decode_queue.sv - OUT_DEPTH-entry circular buffer of completed instructions
//   clk, reset     : clock, asynchronous active-high reset
//   flush          : empty the queue (wins over push/pop)
//   push, push_entry : write an entry at the tail (ignored when full)
//   pop            : advance the head (ignored when empty)
//   head           : head entry, all-zero when empty
//   empty, full, occupancy : fill status

module nec_decode_queue
    import nec_decode_gather_pkg::*;
#(
    parameter int OUT_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  gather_entry_t              push_entry,
    input  logic                       pop,
    output gather_entry_t              head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(OUT_DEPTH):0] occupancy
);

    localparam int            PW         = $clog2(OUT_DEPTH);
    localparam logic [PW:0]   FULL_COUNT = (PW+1)'(OUT_DEPTH);

    gather_entry_t mem_q [OUT_DEPTH];
    gather_entry_t mem_d [OUT_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_COUNT);
    assign occupancy = count_q;
    assign head      = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && !full;
        do_pop   = pop && !empty;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/nec_decode_gather.sv
// rtl/nec_decode_gather.sv - gathers whole instructions from the IPQ into an output queue
//   Optional macro NEC_DECODE_BYPASS_EN: a completing entry is shown on out_* the
//   same cycle when the queue is empty, and is dropped unwritten if retired then.
//   clk, reset        : clock, asynchronous active-high reset
//   ce_1, ce_2        : phase enables (ce_2 honours set_pc only)
//   set_pc, new_pc    : redirect and flush
//   pc                : next IPQ byte address
//   ipq_len, ipq      : valid IPQ bytes from pc, IPQ byte array (index = addr mod IPQ_DEPTH)
//   desc_*            : predecoder descriptor for the instruction at pc
//   out_*, out_ready  : head entry of the output queue and its retire handshake
//   occupancy         : queued entries

module nec_decode_gather
    import nec_decode_gather_pkg::*;
#(
    parameter int IPQ_DEPTH   = 8,
    parameter int FETCH_WIDTH = 2,
    parameter int MAX_LEN     = 8,
    parameter int OUT_DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ce_1,
    input  logic                       ce_2,
    input  logic                       set_pc,
    input  logic [15:0]                new_pc,
    output logic [15:0]                pc,
    input  logic [$clog2(IPQ_DEPTH):0] ipq_len,
    input  logic [8*IPQ_DEPTH-1:0]     ipq,
    input  logic                       desc_valid,
    input  logic [2:0]                 desc_hdr_len,
    input  logic [2:0]                 desc_disp_size,
    input  logic [2:0]                 desc_imm_size,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [8*MAX_LEN-1:0]       out_bytes,
    output logic [3:0]                 out_len,
    output logic [15:0]                out_pc,
    output logic [15:0]                out_end_pc,
    output logic                       out_bad,
    output logic [$clog2(OUT_DEPTH):0] occupancy
);

    localparam int IW = $clog2(IPQ_DEPTH);

    gather_state_e              state_q, state_d;
    logic [15:0]                pc_q, pc_d;
    logic [15:0]                start_pc_q, start_pc_d;
    logic [3:0]                 total_q, total_d;
    logic [3:0]                 remaining_q, remaining_d;
    logic [8*ENTRY_MAX_LEN-1:0] buf_q, buf_d;

    logic          redirect;
    logic [3:0]    desc_tot;
    logic          desc_bad;
    logic          take;
    logic          bad_now;
    logic [3:0]    rem_start;
    int            base_off;
    int            n;
    int            buf_idx;
    logic [IW-1:0] ipq_idx;
    logic          push_req;
    gather_entry_t push_entry;

    logic          q_push, q_pop;
    logic          q_empty, q_full;
    gather_entry_t q_head;
    gather_entry_t out_entry;

    assign pc = pc_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        start_pc_d  = start_pc_q;
        total_d     = total_q;
        remaining_d = remaining_q;
        buf_d       = buf_q;
        take        = 1'b0;
        bad_now     = 1'b0;
        rem_start   = remaining_q;
        base_off    = 0;
        n           = 0;
        buf_idx     = 0;
        ipq_idx     = '0;
        push_req    = 1'b0;
        push_entry  = '0;

        redirect = set_pc && (ce_1 || ce_2);
        desc_tot = desc_total(desc_hdr_len, desc_disp_size, desc_imm_size);
        desc_bad = (desc_tot == 4'd0) || (int'(desc_tot) > MAX_LEN);

        if (redirect) begin
            state_d     = IDLE;
            pc_d        = new_pc;
            total_d     = '0;
            remaining_d = '0;
            buf_d       = '0;
        end else if (ce_1) begin
            case (state_q)
                IDLE: begin
                    // q_full is pre-pop, so a slot freed this cycle is not reused until next cycle.
                    if (desc_valid && (ipq_len != '0) && !q_full) begin
                        take       = 1'b1;
                        start_pc_d = pc_q;
                        buf_d      = '0;
                        if (desc_bad) begin
                            // Illegal descriptor: swallow one byte so fetch keeps moving.
                            bad_now   = 1'b1;
                            total_d   = 4'd1;
                            rem_start = 4'd1;
                        end else begin
                            total_d   = desc_tot;
                            rem_start = desc_tot;
                        end
                    end
                end
                GATHER: begin
                    if (ipq_len != '0) begin
                        take      = 1'b1;
                        rem_start = remaining_q;
                        base_off  = int'(total_q - remaining_q);
                    end
                end
                default: state_d = IDLE;
            endcase

            if (take) begin
                n = int'(rem_start);
                if (n > FETCH_WIDTH) n = FETCH_WIDTH;
                if (n > int'(ipq_len)) n = int'(ipq_len);

                for (int k = 0; k < FETCH_WIDTH; k++) begin
                    if (k < n) begin
                        ipq_idx = pc_q[IW-1:0] + IW'(k);
                        buf_idx = base_off + k;
                        if (buf_idx < ENTRY_MAX_LEN) begin
                            buf_d[8*buf_idx +: 8] = ipq[8*int'(ipq_idx) +: 8];
                        end
                    end
                end

                pc_d        = pc_q + 16'(n);
                remaining_d = rem_start - 4'(n);

                if (remaining_d == 4'd0) begin
                    state_d           = IDLE;
                    push_req          = 1'b1;
                    push_entry.bytes  = buf_d;
                    push_entry.len    = total_d;
                    push_entry.pc     = start_pc_d;
                    push_entry.end_pc = start_pc_d + 16'(total_d);
                    push_entry.bad    = bad_now;
                end else begin
                    state_d = GATHER;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            start_pc_q  <= '0;
            total_q     <= '0;
            remaining_q <= '0;
            buf_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            start_pc_q  <= start_pc_d;
            total_q     <= total_d;
            remaining_q <= remaining_d;
            buf_q       <= buf_d;
        end
    end

    assign q_pop = ce_1 && !redirect && out_ready && !q_empty;

`ifdef NEC_DECODE_BYPASS_EN
    // Only a truly empty queue bypasses; when the last entry is popped in the
    // same cycle the head still shows that entry, so the new one is queued.
    logic bypass;
    assign bypass    = push_req && q_empty;
    assign q_push    = push_req && !(bypass && out_ready);
    assign out_entry = bypass ? push_entry : q_head;
    assign out_valid = !redirect && (bypass || !q_empty);
`else
    assign q_push    = push_req;
    assign out_entry = q_head;
    assign out_valid = !q_empty;
`endif

    assign out_bytes  = out_entry.bytes[8*MAX_LEN-1:0];
    assign out_len    = out_entry.len;
    assign out_pc     = out_entry.pc;
    assign out_end_pc = out_entry.end_pc;
    assign out_bad    = out_entry.bad;

    nec_decode_queue #(
        .OUT_DEPTH (OUT_DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect),
        .push       (q_push),
        .push_entry (push_entry),
        .pop        (q_pop),
        .head       (q_head),
        .empty      (q_empty),
        .full       (q_full),
        .occupancy  (occupancy)
    );

endmodule

// File: tb/tb_nec_decode_gather.sv
// tb/tb_nec_decode_gather.sv - directed self-checking bench for nec_decode_gather

module tb_nec_decode_gather;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce_1, ce_2, set_pc;
    logic [15:0] new_pc;
    logic [15:0] pc;
    logic [3:0]  ipq_len;
    logic [63:0] ipq;
    logic        desc_valid;
    logic [2:0]  desc_hdr_len, desc_disp_size, desc_imm_size;
    logic        out_valid, out_ready;
    logic [63:0] out_bytes;
    logic [3:0]  out_len;
    logic [15:0] out_pc, out_end_pc;
    logic        out_bad;
    logic [2:0]  occupancy;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    nec_decode_gather dut (
        .clk            (clk),
        .reset          (reset),
        .ce_1           (ce_1),
        .ce_2           (ce_2),
        .set_pc         (set_pc),
        .new_pc         (new_pc),
        .pc             (pc),
        .ipq_len        (ipq_len),
        .ipq            (ipq),
        .desc_valid     (desc_valid),
        .desc_hdr_len   (desc_hdr_len),
        .desc_disp_size (desc_disp_size),
        .desc_imm_size  (desc_imm_size),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_bytes      (out_bytes),
        .out_len        (out_len),
        .out_pc         (out_pc),
        .out_end_pc     (out_end_pc),
        .out_bad        (out_bad),
        .occupancy      (occupancy)
    );

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] + (a[15:8] * 8'd3) + 8'h11;
    endfunction

    function automatic logic [63:0] exp_bytes(input logic [15:0] start, input int len);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < len; k++) r[8*k +: 8] = mem_byte(start + 16'(k));
        return r;
    endfunction

    // Memory image seen through the IPQ: slot i holds the byte whose address
    // is congruent to i mod 8 in the window starting at pc.
    always_comb begin
        ipq = '0;
        for (int i = 0; i < 8; i++) begin
            ipq[8*i +: 8] = mem_byte(pc + 16'((i - int'(pc[2:0])) & 7));
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic desc(input logic [2:0] h, input logic [2:0] d, input logic [2:0] i);
        desc_valid     = 1'b1;
        desc_hdr_len   = h;
        desc_disp_size = d;
        desc_imm_size  = i;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ce_1 = 1'b0; ce_2 = 1'b0; set_pc = 1'b0; new_pc = '0;
        ipq_len = 4'd8; desc_valid = 1'b0; desc_hdr_len = '0;
        desc_disp_size = '0; desc_imm_size = '0; out_ready = 1'b0;
        step(); step();
        check("rst_pc", pc, 16'h0000);
        check("rst_occ", occupancy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_len", out_len, 0);
        check("rst_bytes", out_bytes, 0);
        check("rst_endpc", out_end_pc, 0);
        reset = 1'b0;
        ce_1  = 1'b1;

        // 5-byte instruction, two bytes per cycle
        set_pc = 1'b1; new_pc = 16'h0100; step(); set_pc = 1'b0;
        check("setpc_0100", pc, 16'h0100);
        desc(3'd1, 3'd2, 3'd2);
        step(); check("g5_pc1", pc, 16'h0102);
        step(); check("g5_pc2", pc, 16'h0104); check("g5_nv", out_valid, 0);
        step(); desc_valid = 1'b0;
        check("g5_pc3", pc, 16'h0105);
        check("g5_valid", out_valid, 1);
        check("g5_len", out_len, 5);
        check("g5_pc", out_pc, 16'h0100);
        check("g5_end", out_end_pc, 16'h0105);
        check("g5_bytes", out_bytes, exp_bytes(16'h0100, 5));
        pop_one();
        check("g5_popped", occupancy, 0);

        // 4-byte instruction with a trickling IPQ and one empty cycle
        ipq_len = 4'd1; desc(3'd2, 3'd2, 3'd0);
        step(); desc_valid = 1'b0; check("trk_pc1", pc, 16'h0106);
        step(); check("trk_pc2", pc, 16'h0107);
        ipq_len = 4'd0;
        step(); check("trk_stall", pc, 16'h0107); check("trk_stall_nv", out_valid, 0);
        ipq_len = 4'd1;
        step(); check("trk_pc3", pc, 16'h0108);
        step(); check("trk_pc4", pc, 16'h0109);
        check("trk_len", out_len, 4);
        check("trk_opc", out_pc, 16'h0105);
        check("trk_bytes", out_bytes, exp_bytes(16'h0105, 4));
        ipq_len = 4'd8;
        pop_one();

        // fill the queue with 1-byte instructions, then back-pressure
        desc(3'd1, 3'd0, 3'd0);
        for (int i = 0; i < 4; i++) step();
        check("fill_occ", occupancy, 4);
        check("fill_pc", pc, 16'h010D);
        step();
        check("full_occ", occupancy, 4);
        check("full_pc", pc, 16'h010D);
        check("full_head", out_pc, 16'h0109);
        pop_one();
        check("pop_occ", occupancy, 3);
        check("pop_pc", pc, 16'h010D);
        check("pop_head", out_pc, 16'h010A);
        step();
        check("refill_occ", occupancy, 4);
        check("refill_pc", pc, 16'h010E);

        // redirect on ce_2 in the middle of a gather
        desc_valid = 1'b0; pop_one();
        check("mid_occ3", occupancy, 3);
        desc(3'd1, 3'd2, 3'd2);
        step(); desc_valid = 1'b0;
        check("mid_pc", pc, 16'h0110);
        ce_1 = 1'b0; desc(3'd1, 3'd0, 3'd0);
        step(); check("noce_pc", pc, 16'h0110); check("noce_occ", occupancy, 3);
        ce_2 = 1'b1; set_pc = 1'b1; new_pc = 16'h2000; desc_valid = 1'b0;
        step();
        ce_2 = 1'b0; set_pc = 1'b0; ce_1 = 1'b1;
        check("rd_occ", occupancy, 0);
        check("rd_valid", out_valid, 0);
        check("rd_pc", pc, 16'h2000);
        desc(3'd1, 3'd0, 3'd0);
        step(); desc_valid = 1'b0;
        check("rd_idle_valid", out_valid, 1);
        check("rd_idle_opc", out_pc, 16'h2000);
        check("rd_idle_len", out_len, 1);
        check("rd_idle_pc", pc, 16'h2001);
        pop_one();

        // pc wrap across 0xFFFF
        set_pc = 1'b1; new_pc = 16'hFFFE; step(); set_pc = 1'b0;
        desc(3'd3, 3'd0, 3'd0);
        step(); desc_valid = 1'b0; check("wrap_pc1", pc, 16'h0000);
        step(); check("wrap_pc2", pc, 16'h0001);
        check("wrap_opc", out_pc, 16'hFFFE);
        check("wrap_end", out_end_pc, 16'h0001);
        check("wrap_bytes", out_bytes, exp_bytes(16'hFFFE, 3));
        pop_one();

        // illegal descriptors: total 0, 11 and 9 each take one byte
        desc(3'd0, 3'd0, 3'd0);
        step(); desc_valid = 1'b0;
        check("bad0_pc", pc, 16'h0002);
        check("bad0_bad", out_bad, 1);
        check("bad0_len", out_len, 1);
        check("bad0_end", out_end_pc, 16'h0002);
        pop_one();
        desc(3'd5, 3'd2, 3'd4);
        step(); desc_valid = 1'b0;
        check("bad11_pc", pc, 16'h0003);
        check("bad11_bad", out_bad, 1);
        check("bad11_len", out_len, 1);
        check("bad11_opc", out_pc, 16'h0002);
        pop_one();
        // largest legal instruction
        desc(3'd4, 3'd2, 3'd2);
        step(); desc_valid = 1'b0;
        step(); step(); step();
        check("max_pc", pc, 16'h000B);
        check("max_len", out_len, 8);
        check("max_bad", out_bad, 0);
        check("max_bytes", out_bytes, exp_bytes(16'h0003, 8));
        pop_one();
        desc(3'd5, 3'd2, 3'd2);
        step(); desc_valid = 1'b0;
        check("bad9_pc", pc, 16'h000C);
        check("bad9_bad", out_bad, 1);

        // asynchronous reset takes effect without a clock edge
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("arst_pc", pc, 16'h0000);
        check("arst_occ", occupancy, 0);
        check("arst_bad", out_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
